// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles 5-byte command frames (HEADER, CODE, PH, PL, CHK) from the UART
// byte stream. CHK must equal CODE ^ PH ^ PL. Good frames raise a one-cycle
// cmd_valid strobe and load the held cmd_code/cmd_param registers. Bad frames
// raise a one-cycle frame_err strobe and bump a saturating err_cnt.
//
// Optional feature: define CMD_TIMEOUT_EN to build an inter-byte timeout that
// abandons a partial frame after TIMEOUT_CYCLES idle clocks and reports it as
// a frame error. Without the macro a partial frame waits indefinitely.

module uart_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter logic [7:0]  MAX_CMD        = 8'h08,
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_param,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  // One state per expected byte position; IDLE hunts for the header.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_PH,
    ST_PL,
    ST_CHK
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  code_sh;
  logic [7:0]  ph_sh;
  logic [7:0]  pl_sh;
  logic [7:0]  xor_acc;

  logic        good_frame;
  logic        bad_frame;
  logic        timeout_hit;
  logic        leave_frame;
  logic        any_err;

`ifdef CMD_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] tmo_cnt;

  // A byte arriving in the terminal-count cycle wins, so the timeout only
  // fires when no byte is present.
  assign timeout_hit = (state != ST_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

  // Idle-clock counter: runs only inside a frame and restarts on every byte.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == ST_IDLE) || rx_valid || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 17'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign leave_frame = (state != ST_IDLE) && (next_state == ST_IDLE);
  assign any_err     = bad_frame || timeout_hit;
  assign busy        = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the frame verdict, evaluated on the CHK byte.
  always_comb begin
    next_state = state;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_data == HEADER)) begin
          next_state = ST_CODE;
        end
      end
      ST_CODE: begin
        if (rx_valid) begin
          next_state = ST_PH;
        end
      end
      ST_PH: begin
        if (rx_valid) begin
          next_state = ST_PL;
        end
      end
      ST_PL: begin
        if (rx_valid) begin
          next_state = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          next_state = ST_IDLE;
          if ((rx_data == xor_acc) && (code_sh <= MAX_CMD)) begin
            good_frame = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (timeout_hit) begin
      next_state = ST_IDLE;
    end
  end

  // Shadow registers and running checksum; wiped whenever the frame ends so
  // the next header always starts from a clean XOR.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      code_sh <= '0;
      ph_sh   <= '0;
      pl_sh   <= '0;
      xor_acc <= '0;
    end else if (leave_frame) begin
      code_sh <= '0;
      ph_sh   <= '0;
      pl_sh   <= '0;
      xor_acc <= '0;
    end else if (rx_valid) begin
      case (state)
        ST_CODE: begin
          code_sh <= rx_data;
          xor_acc <= xor_acc ^ rx_data;
        end
        ST_PH: begin
          ph_sh   <= rx_data;
          xor_acc <= xor_acc ^ rx_data;
        end
        ST_PL: begin
          pl_sh   <= rx_data;
          xor_acc <= xor_acc ^ rx_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Output strobes, held command registers and the saturating error count.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_code  <= '0;
      cmd_param <= '0;
      err_cnt   <= '0;
    end else begin
      cmd_valid <= good_frame;
      frame_err <= any_err;
      if (good_frame) begin
        cmd_code  <= code_sh;
        cmd_param <= {ph_sh, pl_sh};
      end
      if (any_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Scoreboard bench for uart_cmd_parser: stimulus pushes the expected response
// of each frame into a queue; a monitor pops and compares whenever the DUT
// raises cmd_valid or frame_err. Define CMD_TIMEOUT_EN for both files to
// exercise the timeout build.

`timescale 1ns/1ps

module tb_uart_cmd_parser;

  logic        clk_50M  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_param;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  uart_cmd_parser dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_param (cmd_param),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  // 50 MHz clock.
  always #10 clk_50M = ~clk_50M;

  typedef struct {
    bit          is_err;
    logic [7:0]  code;
    logic [15:0] param;
    logic [7:0]  cnt;
    int unsigned cyc;
    bit          chk_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  logic [7:0]  m_code  = 8'h00;
  logic [15:0] m_param = 16'h0000;
  logic [7:0]  m_cnt   = 8'h00;

  // Cycle index; a byte driven while cyc==K-1 is answered while cyc==K+... see expectFrame.
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one byte for exactly one clock; called and returns at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk_50M);
    rx_valid = 1'b0;
  endtask

  // Reference model of a completed frame; must be called just before its CHK byte is driven.
  task automatic expectFrame(input logic [7:0] code, input logic [7:0] ph,
                             input logic [7:0] pl, input logic [7:0] chk);
    exp_t e;
    bit   good;
    good = (chk == (code ^ ph ^ pl)) && (code <= 8'h08);
    if (good) begin
      m_code  = code;
      m_param = {ph, pl};
    end else if (m_cnt != 8'hFF) begin
      m_cnt = m_cnt + 8'd1;
    end
    e.is_err  = !good;
    e.code    = m_code;
    e.param   = m_param;
    e.cnt     = m_cnt;
    e.cyc     = cyc + 1;
    e.chk_cyc = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic sendFrame(input logic [7:0] code, input logic [7:0] ph,
                           input logic [7:0] pl, input logic [7:0] chk);
    applyStimulus(8'hAA);
    applyStimulus(code);
    applyStimulus(ph);
    applyStimulus(pl);
    expectFrame(code, ph, pl, chk);
    applyStimulus(chk);
  endtask

  // Wait (bounded) until every queued response has been observed.
  task automatic waitDrain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0) && (n < bound)) begin
      @(negedge clk_50M);
      n++;
    end
    repeat (3) @(negedge clk_50M);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every strobe from the DUT must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50M);
      if (cmd_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected: cmd_valid=%0b frame_err=%0b at cycle %0d, expected none",
                   cmd_valid, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
          checkOutput("cmd_valid", {31'd0, cmd_valid}, {31'd0, !e.is_err});
          checkOutput("cmd_code", {24'd0, cmd_code}, {24'd0, e.code});
          checkOutput("cmd_param", {16'd0, cmd_param}, {16'd0, e.param});
          checkOutput("err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
          if (e.chk_cyc) begin
            checkOutput("latency", cyc, e.cyc);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;

    // Reset values.
    repeat (3) @(negedge clk_50M);
    checkOutput("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("rst frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst cmd_code", {24'd0, cmd_code}, 32'd0);
    checkOutput("rst cmd_param", {16'd0, cmd_param}, 32'd0);
    checkOutput("rst err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // Good frame 03/1234: checksum 03^12^34 = 25; busy tracks the frame.
    applyStimulus(8'hAA);
    checkOutput("busy after header", {31'd0, busy}, 32'd1);
    applyStimulus(8'h03);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    expectFrame(8'h03, 8'h12, 8'h34, 8'h25);
    applyStimulus(8'h25);
    checkOutput("busy after chk", {31'd0, busy}, 32'd0);
    waitDrain(10);

    // Bad checksums leave code/param held.
    sendFrame(8'h03, 8'h12, 8'h34, 8'h26);
    waitDrain(10);
    sendFrame(8'h03, 8'h12, 8'h34, 8'h27);
    waitDrain(10);

    // Illegal code, then the highest legal code, back to back.
    sendFrame(8'h09, 8'h00, 8'h00, 8'h09);
    sendFrame(8'h08, 8'h00, 8'h01, 8'h09);
    waitDrain(10);

    // Junk ahead of the header, then a header byte used as CODE.
    applyStimulus(8'h55);
    applyStimulus(8'h00);
    checkOutput("busy on junk", {31'd0, busy}, 32'd0);
    sendFrame(8'hAA, 8'h00, 8'h00, 8'hAA);
    waitDrain(10);

    // Stalled partial frame.
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
`ifdef CMD_TIMEOUT_EN
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.is_err  = 1'b1;
    e.code    = m_code;
    e.param   = m_param;
    e.cnt     = m_cnt;
    e.cyc     = 0;
    e.chk_cyc = 1'b0;
    exp_q.push_back(e);
    waitDrain(50_100);
    checkOutput("busy after timeout", {31'd0, busy}, 32'd0);
    sendFrame(8'h01, 8'h00, 8'h00, 8'h01);
    waitDrain(10);
`else
    repeat (200) @(negedge clk_50M);
    checkOutput("busy while stalled", {31'd0, busy}, 32'd1);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    expectFrame(8'h01, 8'h00, 8'h00, 8'h01);
    applyStimulus(8'h01);
    waitDrain(10);
`endif

    // Back-to-back good frames: 01^02^03 = 00, 05^A5^5A = FA.
    sendFrame(8'h01, 8'h02, 8'h03, 8'h00);
    sendFrame(8'h05, 8'hA5, 8'h5A, 8'hFA);
    waitDrain(10);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      sendFrame(8'h01, 8'h00, 8'h00, 8'h00);
    end
    waitDrain(10);
    checkOutput("err_cnt saturated", {24'd0, err_cnt}, 32'h0000_00FF);

    // Reset in the middle of a frame discards it silently.
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    applyStimulus(8'h12);
    rst_n   = 1'b0;
    m_code  = 8'h00;
    m_param = 16'h0000;
    m_cnt   = 8'h00;
    #1;
    checkOutput("midrst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("midrst frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("midrst cmd_code", {24'd0, cmd_code}, 32'd0);
    checkOutput("midrst cmd_param", {16'd0, cmd_param}, 32'd0);
    checkOutput("midrst err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("midrst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    sendFrame(8'h07, 8'h00, 8'hFF, 8'hF8);
    waitDrain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
